// File: rtl/cordic_floatingpoint_addsub_normalizer_pkg.sv
// Shared constants, FSM encoding and the IEEE-754 single-precision packer
// for the add/sub post-normalizer.
package cordic_floatingpoint_addsub_normalizer_pkg;

    localparam int MANT_W   = 24;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = MANT_W - 1;
    localparam int WORD_W   = 32;
    localparam int SIGN_POS = WORD_W - 1;
    localparam int EXP_LSB  = FRAC_W;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } norm_state_t;

    function automatic logic [WORD_W-1:0] pack_sp(input logic s,
                                                  input logic [EXP_W-1:0] e,
                                                  input logic [FRAC_W-1:0] f);
        logic [WORD_W-1:0] r;
        r                     = '0;
        r[SIGN_POS]           = s;
        r[EXP_LSB +: EXP_W]   = e;
        r[FRAC_W-1:0]         = f;
        return r;
    endfunction

endpackage

// File: rtl/cordic_floatingpoint_addsub_normalizer_cla_adder.sv
// 24-bit carry-lookahead adder/subtractor built from 4-bit lookahead groups;
// addsub=1 computes iA - iB as iA + ~iB + 1.
module cordic_floatingpoint_addsub_CLA_adder
    import cordic_floatingpoint_addsub_normalizer_pkg::*;
(
    input  logic [MANT_W-1:0] iA,
    input  logic [MANT_W-1:0] iB,
    input  logic              addsub,
    output logic [MANT_W-1:0] oSum
);
    localparam int GRP = 4;
    localparam int NG  = MANT_W / GRP;

    logic [MANT_W-1:0] b, p, g, c;

    assign b    = iB ^ {MANT_W{addsub}};
    assign p    = iA ^ b;
    assign g    = iA & b;
    assign c[0] = addsub;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int B = k * GRP;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        // The final group's carry-out is never needed.
        if (k < NG-1) begin : g_cout
            assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B])
                          | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
        end
    end

    assign oSum = p ^ c;

endmodule

// File: rtl/cordic_floatingpoint_addsub_normalizer.sv
// Post-adder normalizer: loads the raw add/sub result, shifts left one bit
// per cycle until the hidden bit is set, then packs a single-precision word.
module cordic_floatingpoint_addsub_normalizer
    import cordic_floatingpoint_addsub_normalizer_pkg::*;
(
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              iValid,
    output logic              oReady,
    input  logic [MANT_W-1:0] iSum,
    input  logic              iCarry,
    input  logic              iAddsub,
    input  logic              iSign,
    input  logic [EXP_W-1:0]  iExp,
    output logic              oValid,
    input  logic              iReady,
    output logic [WORD_W-1:0] oResult,
    output logic              oZero,
    output logic              oOverflow,
    output logic              oUnderflow
);
    norm_state_t       state;
    logic [MANT_W-1:0] mant, neg, ld_mant, sh_mant;
    logic [EXP_W-1:0]  exp_r, ld_exp, exp_dec;
    logic [EXP_W:0]    exp_inc;
    logic              sign_r, ld_sign, ld_ovf;

    cordic_floatingpoint_addsub_CLA_adder u_neg (
        .iA     ('0),
        .iB     (iSum),
        .addsub (1'b1),
        .oSum   (neg)
    );

    always_comb begin
        exp_inc = {1'b0, iExp} + 9'd1;
        ld_mant = iSum;
        ld_exp  = iExp;
        ld_sign = iSign;
        if (!iAddsub && iCarry) begin
            ld_mant = {1'b1, iSum[MANT_W-1:1]};
            ld_exp  = exp_inc[EXP_W-1:0];
        end else if (iAddsub && iCarry) begin
            ld_mant = neg;
            ld_sign = ~iSign;
        end
        ld_ovf = (iExp == EXP_MAX) || (!iAddsub && iCarry && (exp_inc >= {1'b0, EXP_MAX}));
    end

    assign sh_mant = {mant[MANT_W-2:0], 1'b0};
    assign exp_dec = exp_r - 8'd1;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state      <= S_IDLE;
            oReady     <= 1'b1;
            oValid     <= 1'b0;
            oResult    <= '0;
            oZero      <= 1'b0;
            oOverflow  <= 1'b0;
            oUnderflow <= 1'b0;
            mant       <= '0;
            exp_r      <= '0;
            sign_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (iValid) begin
                    oReady     <= 1'b0;
                    mant       <= ld_mant;
                    exp_r      <= ld_exp;
                    sign_r     <= ld_sign;
                    oResult    <= '0;
                    oZero      <= 1'b0;
                    oOverflow  <= 1'b0;
                    oUnderflow <= 1'b0;
                    if (ld_ovf) begin
                        oResult   <= pack_sp(ld_sign, EXP_MAX, '0);
                        oOverflow <= 1'b1;
                        oValid    <= 1'b1;
                        state     <= S_DONE;
                    end else if (ld_mant == '0) begin
                        oZero  <= 1'b1;
                        oValid <= 1'b1;
                        state  <= S_DONE;
                    end else if (ld_mant[MANT_W-1]) begin
                        oResult <= pack_sp(ld_sign, ld_exp, ld_mant[FRAC_W-1:0]);
                        oValid  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (mant[MANT_W-1]) begin
                        oResult <= pack_sp(sign_r, exp_r, mant[FRAC_W-1:0]);
                        oValid  <= 1'b1;
                        state   <= S_DONE;
                    end else if (exp_r <= 8'd1) begin
                        oUnderflow <= 1'b1;
                        oValid     <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        mant  <= sh_mant;
                        exp_r <= exp_dec;
                        // Finish on the shift that sets the hidden bit, saving a cycle.
                        if (mant[MANT_W-2]) begin
                            oResult <= pack_sp(sign_r, exp_dec, sh_mant[FRAC_W-1:0]);
                            oValid  <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: if (iReady) begin
                    oValid <= 1'b0;
                    oReady <= 1'b1;
                    state  <= S_IDLE;
                end
                default: begin
                    oValid <= 1'b0;
                    oReady <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cordic_floatingpoint_addsub_normalizer.md
# cordic_floatingpoint_addsub_normalizer

Post-adder normalizer and packer for the CORDIC floating-point add/sub path. It consumes the raw 24-bit mantissa result, carry/borrow flag, common exponent and sign produced by the aligned mantissa add/sub stage. It then renormalizes the mantissa iteratively, one bit per cycle, and emits a packed IEEE-754 single-precision word. A valid/ready handshake sits on both sides.

## Interface
- No parameters; widths are fixed by package constants.
- iClk  input  1  clock; all state updates on its rising edge
- iRstn  input  1  asynchronous, active-low reset
- iValid  input  1  upstream operand valid
- oReady  output  1  block can accept; high only in IDLE
- iSum  input  24  raw mantissa result from the add/sub stage
- iCarry  input  1  meaning depends on iAddsub
  - add: carry-out
  - sub: borrow, set when A<B
- iAddsub  input  1  0 = add, 1 = subtract
- iSign  input  1  sign of operand A
- iExp  input  8  common biased exponent after alignment
- oValid  output  1  result valid; held until accepted
- iReady  input  1  downstream accepts
- oResult  output  32  packed result {sign, exp[7:0], mant[22:0]}
- oZero, oOverflow, oUnderflow  output  1 each  status flags qualified by oValid

## Operation
- FSM states: IDLE, NORM, DONE.
- Accept: an edge with iValid & oReady. The load path below is evaluated combinationally on that edge.
- Load path, add with iCarry=1:
  - mant = {1, iSum[23:1]} (truncation, no rounding); exp = iExp+1; sign = iSign.
  - If iExp+1 >= 255: overflow case.
  - Go to DONE.
- Load path, sub with iCarry=1:
  - mant = (~iSum)+1, 24-bit; sign = ~iSign; exp = iExp.
- Load path, otherwise:
  - mant = iSum; sign = iSign; exp = iExp.
- Dispatch after the non-carry load:
  - mant==0: zero case.
  - mant[23]==1: go to DONE.
  - Else: go to NORM.
- Input iExp==255 is treated as the overflow case.
- NORM, one step per cycle:
  - If mant[23]==1: go to DONE.
  - Else if exp<=1: underflow case.
  - Else: mant <<= 1, exp -= 1.
- Zero case: result 0x00000000, oZero=1; sign is forced positive.
- Overflow case: result {sign, 8'hFF, 23'h0}, oOverflow=1.
- Underflow case: result 0x00000000, oUnderflow=1 (flush-to-zero, no denormals).
- DONE:
  - oValid=1; oResult and all flags are held stable.
  - On iReady: go to IDLE.
- At most one flag is set per result.

## Timing
- Reset values: state IDLE, oReady=1, oValid=0, oResult=0, all flags 0.
- Latency from the accept edge to oValid high:
  - 1 edge for the carry, zero, overflow and already-normalized cases.
  - 1+L edges otherwise, where L = leading zeros of the loaded mantissa (1..23).
- Underflow latency: oValid rises at or before the edge at which exp would reach 0.
- oReady is low from the accept edge until the edge after DONE&iReady; no accept occurs in the DONE cycle.
- Throughput: one result per 2+L cycles minimum.
- Backpressure: DONE may be held indefinitely; outputs do not change while iValid toggles.
- Reset mid-operation (NORM or DONE): immediate return to IDLE, oValid=0, the result is discarded, and oReady=1 after release.

## Structure
- Shared package contents:
  - FSM state encodings.
  - MANT_W=24, EXP_W=8, EXP_MAX=8'hFF.
  - Packing field offsets.
- One sub-module: an instance of cordic_floatingpoint_addsub_CLA_adder used as the negator, with iA=0, iB=iSum, addsub=1. This produces (~iSum)+1 on the borrow path.
- All other logic stays inline: the FSM, the mantissa/exponent registers and the packing.

## Test plan
- Add: iCarry=1, iSum=0x800000, iExp=127, iSign=0 -> oResult=0x40400000, oValid after 1 edge.
- Sub: iCarry=0, iSum=0x200000, iExp=127 -> oResult=0x3E800000, oValid after 3 edges.
- Sub with borrow: iCarry=1, iSum=0xC00000, iExp=127, iSign=0 -> oResult=0xBF000000.
- Zero: sub, iSum=0, iCarry=0 -> oResult=0, oZero=1 after 1 edge.
- Overflow and underflow:
  - Add, iCarry=1, iExp=254 -> oResult=0x7F800000, oOverflow=1.
  - Sub, iSum=0x000001, iExp=5 -> oResult=0, oUnderflow=1.
- Backpressure and reset:
  - iReady=0 for 5 cycles in DONE -> oValid, oResult and oReady=0 remain stable.
  - iRstn low during NORM -> oValid=0, oReady=1, no result emitted.
